// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 16x16 register_file: round-robin arbitration between
// two writeback requesters plus a clear sequencer that sweeps CLEAR_VALUE into every register.
module regfile_write_arbiter #(
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    ADDR_WIDTH     = 4,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    parameter bit                    CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req0_i,
    input  logic [ADDR_WIDTH-1:0] da0_i,
    input  logic [DATA_WIDTH-1:0] d0_i,
    output logic                  ack0_o,
    input  logic                  req1_i,
    input  logic [ADDR_WIDTH-1:0] da1_i,
    input  logic [DATA_WIDTH-1:0] d1_i,
    output logic                  ack1_o,
    input  logic                  clr_start_i,
    output logic                  clr_busy_o,
    output logic                  rf_rw_o,
    output logic [ADDR_WIDTH-1:0] rf_da_o,
    output logic [DATA_WIDTH-1:0] rf_d_o
);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam state_t                ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  rf_rw_q, rf_rw_d;
    logic [ADDR_WIDTH-1:0] rf_da_q, rf_da_d;
    logic [DATA_WIDTH-1:0] rf_d_q, rf_d_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_RESET;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            rf_rw_q      <= 1'b0;
            rf_da_q      <= '0;
            rf_d_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            rf_rw_q      <= rf_rw_d;
            rf_da_q      <= rf_da_d;
            rf_d_q       <= rf_d_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        rf_rw_d      = 1'b0;
        rf_da_d      = rf_da_q;
        rf_d_d       = rf_d_q;
        ack0_o       = 1'b0;
        ack1_o       = 1'b0;

        if (state_q == ST_CLEAR) begin
            rf_rw_d = 1'b1;
            rf_da_d = cnt_q;
            rf_d_d  = CLEAR_VALUE;
            cnt_d   = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
                state_d = ST_ARB;
                cnt_d   = '0;
            end
        end else if (!reset_i) begin
            // A clear request wins the cycle outright; requesters simply keep waiting.
            if (clr_start_i) begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end else if (req0_i && (!req1_i || last_grant_q)) begin
                ack0_o       = 1'b1;
                rf_rw_d      = 1'b1;
                rf_da_d      = da0_i;
                rf_d_d       = d0_i;
                last_grant_d = 1'b0;
            end else if (req1_i) begin
                ack1_o       = 1'b1;
                rf_rw_d      = 1'b1;
                rf_da_d      = da1_i;
                rf_d_d       = d1_i;
                last_grant_d = 1'b1;
            end
        end
    end

    assign clr_busy_o = (state_q == ST_CLEAR);
    assign rf_rw_o    = rf_rw_q;
    assign rf_da_o    = rf_da_q;
    assign rf_d_o     = rf_d_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register_file
// fed from the arbiter's write port; a second instance covers CLEAR_ON_RESET = 0.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, clr_start;
    logic [3:0]  da0, da1;
    logic [15:0] d0, d1;
    logic        ack0, ack1, clr_busy, rf_rw;
    logic [3:0]  rf_da;
    logic [15:0] rf_d;

    logic        rst_nc, n_req0, n_req1;
    logic        n_ack0, n_ack1, n_busy, n_rw;
    logic [3:0]  n_da;
    logic [15:0] n_d;

    logic        mem_init;
    logic [15:0] rf_mem [16];

    int tests;
    int fails;

    regfile_write_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .CLEAR_VALUE(16'h0000),
                            .CLEAR_ON_RESET(1'b1)) dut (
        .clk_i(clk), .reset_i(reset),
        .req0_i(req0), .da0_i(da0), .d0_i(d0), .ack0_o(ack0),
        .req1_i(req1), .da1_i(da1), .d1_i(d1), .ack1_o(ack1),
        .clr_start_i(clr_start), .clr_busy_o(clr_busy),
        .rf_rw_o(rf_rw), .rf_da_o(rf_da), .rf_d_o(rf_d)
    );

    regfile_write_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .CLEAR_VALUE(16'h0000),
                            .CLEAR_ON_RESET(1'b0)) dut_nc (
        .clk_i(clk), .reset_i(rst_nc),
        .req0_i(n_req0), .da0_i(da0), .d0_i(d0), .ack0_o(n_ack0),
        .req1_i(n_req1), .da1_i(da1), .d1_i(d1), .ack1_o(n_ack1),
        .clr_start_i(1'b0), .clr_busy_o(n_busy),
        .rf_rw_o(n_rw), .rf_da_o(n_da), .rf_d_o(n_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // register_file write side: RW/DA/D sampled on the rising edge
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 16'hDEAD;
        end else if (rf_rw) begin
            rf_mem[rf_da] <= rf_d;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_sweep();
        reset = 1'b1;
        tick();
        mem_init = 1'b0;
        tick();
        tests++;
        if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_acks: got %b%b want 00", ack0, ack1);
        end
        tests++;
        if (rf_rw !== 1'b0 || rf_da !== 4'd0 || rf_d !== 16'd0) begin
            fails++;
            $display("FAIL reset_port: got rw=%b da=%h d=%h want 0 0 0", rf_rw, rf_da, rf_d);
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (clr_busy !== 1'b1) begin
                fails++;
                $display("FAIL sweep_busy[%0d]: got %b want 1", i, clr_busy);
            end
            tick();
            tests++;
            if (rf_rw !== 1'b1 || rf_da !== 4'(i) || rf_d !== 16'h0000) begin
                fails++;
                $display("FAIL sweep_write[%0d]: got rw=%b da=%h d=%h want 1 %h 0000",
                         i, rf_rw, rf_da, rf_d, 4'(i));
            end
        end
        tests++;
        if (clr_busy !== 1'b0) begin
            fails++;
            $display("FAIL sweep_end_busy: got %b want 0", clr_busy);
        end
        tick();
        tests++;
        if (rf_rw !== 1'b0) begin
            fails++;
            $display("FAIL idle_rw: got %b want 0", rf_rw);
        end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (rf_mem[i] !== 16'h0000) begin
                fails++;
                $display("FAIL cleared_reg[%0d]: got %h want 0000", i, rf_mem[i]);
            end
        end
    endtask

    task automatic test_single_writes();
        req0 = 1'b1; da0 = 4'd0; d0 = 16'h0005;
        #1;
        tests++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
            fails++;
            $display("FAIL single0_ack: got %b%b want 10", ack0, ack1);
        end
        tick();
        req0 = 1'b0;
        tests++;
        if (rf_rw !== 1'b1 || rf_da !== 4'd0 || rf_d !== 16'h0005) begin
            fails++;
            $display("FAIL single0_port: got rw=%b da=%h d=%h want 1 0 0005", rf_rw, rf_da, rf_d);
        end
        req1 = 1'b1; da1 = 4'd1; d1 = 16'h0006;
        #1;
        tests++;
        if (ack1 !== 1'b1 || ack0 !== 1'b0) begin
            fails++;
            $display("FAIL single1_ack: got %b%b want 01", ack0, ack1);
        end
        tick();
        req1 = 1'b0;
        tests++;
        if (rf_rw !== 1'b1 || rf_da !== 4'd1 || rf_d !== 16'h0006) begin
            fails++;
            $display("FAIL single1_port: got rw=%b da=%h d=%h want 1 1 0006", rf_rw, rf_da, rf_d);
        end
        tick();
        tick();
        tests++;
        if (rf_mem[0] !== 16'h0005 || rf_mem[1] !== 16'h0006) begin
            fails++;
            $display("FAIL single_regs: got A=%h B=%h want 0005 0006", rf_mem[0], rf_mem[1]);
        end
    endtask

    task automatic test_contention();
        req0 = 1'b1; da0 = 4'd2; d0 = 16'hAAAA;
        req1 = 1'b1; da1 = 4'd3; d1 = 16'hBBBB;
        #1;
        tests++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
            fails++;
            $display("FAIL contend_first: got %b%b want 10", ack0, ack1);
        end
        tick();
        req0 = 1'b0;
        #1;
        tests++;
        if (ack0 !== 1'b0 || ack1 !== 1'b1) begin
            fails++;
            $display("FAIL contend_second: got %b%b want 01", ack0, ack1);
        end
        tick();
        req1 = 1'b0;
        tests++;
        if (rf_rw !== 1'b1 || rf_da !== 4'd3 || rf_d !== 16'hBBBB) begin
            fails++;
            $display("FAIL contend_port: got rw=%b da=%h d=%h want 1 3 bbbb", rf_rw, rf_da, rf_d);
        end
        req0 = 1'b1; da0 = 4'd4; d0 = 16'h1111;
        req1 = 1'b1; da1 = 4'd5; d1 = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            #1;
            tests++;
            if (ack0 !== ((k % 2) == 0) || ack1 !== ((k % 2) == 1)) begin
                fails++;
                $display("FAIL alternate[%0d]: got %b%b want %b%b", k, ack0, ack1,
                         (k % 2) == 0, (k % 2) == 1);
            end
            tick();
            tests++;
            if (rf_rw !== 1'b1 || rf_da !== (((k % 2) == 0) ? 4'd4 : 4'd5)) begin
                fails++;
                $display("FAIL alternate_port[%0d]: got rw=%b da=%h", k, rf_rw, rf_da);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        tests++;
        if (rf_mem[2] !== 16'hAAAA || rf_mem[3] !== 16'hBBBB ||
            rf_mem[4] !== 16'h1111 || rf_mem[5] !== 16'h2222) begin
            fails++;
            $display("FAIL contend_regs: got %h %h %h %h want aaaa bbbb 1111 2222",
                     rf_mem[2], rf_mem[3], rf_mem[4], rf_mem[5]);
        end
    endtask

    task automatic test_clear_vs_request();
        int n;
        req1 = 1'b1; da1 = 4'd7; d1 = 16'h7777;
        clr_start = 1'b1;
        #1;
        tests++;
        if (ack1 !== 1'b0 || ack0 !== 1'b0) begin
            fails++;
            $display("FAIL clr_blocks_ack: got %b%b want 00", ack0, ack1);
        end
        tick();
        clr_start = 1'b0;
        n = 0;
        while (clr_busy === 1'b1 && n < 40) begin
            clr_start = (n == 5);
            #1;
            if (ack1 !== 1'b0) begin
                tests++;
                fails++;
                $display("FAIL clr_ack_held[%0d]: got %b want 0", n, ack1);
            end
            tick();
            n++;
        end
        clr_start = 1'b0;
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL clr_len: got %0d want 16", n);
        end
        tests++;
        if (ack1 !== 1'b1 || rf_rw !== 1'b1 || rf_da !== 4'd15) begin
            fails++;
            $display("FAIL post_clr_grant: got ack1=%b rw=%b da=%h want 1 1 f", ack1, rf_rw, rf_da);
        end
        tick();
        req1 = 1'b0;
        tests++;
        if (rf_rw !== 1'b1 || rf_da !== 4'd7 || rf_d !== 16'h7777) begin
            fails++;
            $display("FAIL no_bubble: got rw=%b da=%h d=%h want 1 7 7777", rf_rw, rf_da, rf_d);
        end
        tick();
        tick();
        tests++;
        if (rf_mem[7] !== 16'h7777 || rf_mem[2] !== 16'h0000 || rf_mem[15] !== 16'h0000) begin
            fails++;
            $display("FAIL clr_regs: got r7=%h r2=%h r15=%h want 7777 0000 0000",
                     rf_mem[7], rf_mem[2], rf_mem[15]);
        end
    endtask

    task automatic test_reset_mid_sweep();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        tests++;
        if (clr_busy !== 1'b1 || rf_da !== 4'd6) begin
            fails++;
            $display("FAIL mid_sweep_pos: got busy=%b da=%h want 1 6", clr_busy, rf_da);
        end
        reset = 1'b1;
        req0 = 1'b1;
        #1;
        tests++;
        if (ack0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_ack0: got %b want 0", ack0);
        end
        tick();
        req0 = 1'b0;
        tests++;
        if (rf_rw !== 1'b0 || clr_busy !== 1'b1) begin
            fails++;
            $display("FAIL abort: got rw=%b busy=%b want 0 1", rf_rw, clr_busy);
        end
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            tests++;
            if (rf_rw !== 1'b1 || rf_da !== 4'(i)) begin
                fails++;
                $display("FAIL restart[%0d]: got rw=%b da=%h want 1 %h", i, rf_rw, rf_da, 4'(i));
            end
        end
        tests++;
        if (clr_busy !== 1'b0) begin
            fails++;
            $display("FAIL restart_end: got busy=%b want 0", clr_busy);
        end
    endtask

    task automatic test_no_clear_on_reset();
        rst_nc = 1'b1;
        n_req0 = 1'b1;
        n_req1 = 1'b1;
        da0 = 4'd9; d0 = 16'h9999;
        da1 = 4'd8; d1 = 16'h8888;
        tick();
        tests++;
        if (n_busy !== 1'b0 || n_ack0 !== 1'b0 || n_ack1 !== 1'b0) begin
            fails++;
            $display("FAIL nc_reset: got busy=%b acks=%b%b want 0 00", n_busy, n_ack0, n_ack1);
        end
        rst_nc = 1'b0;
        #1;
        tests++;
        if (n_ack0 !== 1'b1 || n_ack1 !== 1'b0) begin
            fails++;
            $display("FAIL nc_first_grant: got %b%b want 10", n_ack0, n_ack1);
        end
        tick();
        n_req0 = 1'b0;
        tests++;
        if (n_rw !== 1'b1 || n_da !== 4'd9 || n_d !== 16'h9999) begin
            fails++;
            $display("FAIL nc_port: got rw=%b da=%h d=%h want 1 9 9999", n_rw, n_da, n_d);
        end
        #1;
        tests++;
        if (n_ack1 !== 1'b1) begin
            fails++;
            $display("FAIL nc_second_grant: got %b want 1", n_ack1);
        end
        tick();
        n_req1 = 1'b0;
        tests++;
        if (n_da !== 4'd8 || n_d !== 16'h8888) begin
            fails++;
            $display("FAIL nc_port1: got da=%h d=%h want 8 8888", n_da, n_d);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        mem_init = 1'b1;
        reset = 1'b1;
        rst_nc = 1'b1;
        req0 = 1'b0; req1 = 1'b0; clr_start = 1'b0;
        n_req0 = 1'b0; n_req1 = 1'b0;
        da0 = '0; da1 = '0; d0 = '0; d1 = '0;
        test_reset_sweep();
        test_single_writes();
        test_contention();
        test_clear_vs_request();
        test_reset_mid_sweep();
        test_no_clear_on_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (RW, DA, D) of the 16x16 register_file.
- Shares that port between two writeback requesters (port 0: ALU result, port 1: load/immediate path) using round-robin arbitration and a req/ack handshake.
- Runs a clear sequencer that writes CLEAR_VALUE to all 16 registers after reset or on command.
- Sits between the datapath writeback sources and register_file. Read ports AA/BA are not touched by this block.

Parameters:
- DATA_WIDTH, 16, width of register data.
- ADDR_WIDTH, 4, register address width; the sweep covers 2**ADDR_WIDTH registers.
- CLEAR_VALUE, 16'h0000, value written to each register during a clear sweep.
- CLEAR_ON_RESET, 1, 1 = a sweep starts automatically when reset is released; 0 = the block idles in ARB after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 write request.
- da0  in  ADDR_WIDTH  port 0 destination register.
- d0  in  DATA_WIDTH  port 0 write data.
- ack0  out  1  port 0 grant; a transfer occurs on any edge where req0 and ack0 are both high.
- req1  in  1  port 1 write request.
- da1  in  ADDR_WIDTH  port 1 destination register.
- d1  in  DATA_WIDTH  port 1 write data.
- ack1  out  1  port 1 grant; same transfer rule as port 0.
- clr_start  in  1  single-cycle request to start a clear sweep.
- clr_busy  out  1  high while a sweep is in progress.
- rf_rw  out  1  drives register_file RW.
- rf_da  out  ADDR_WIDTH  drives register_file DA.
- rf_d  out  DATA_WIDTH  drives register_file D.

Behaviour:
- Clock is clk. Reset is synchronous and active-high.
- State machine:
  - States: ARB, CLEAR.
  - Reset sets state = CLEAR if CLEAR_ON_RESET is 1, otherwise ARB.
  - Reset also sets cnt = 0, last_grant = 1, rf_rw = 0, rf_da = 0, rf_d = 0.
- Output reset values:
  - ack0 = ack1 = 0 while reset is high.
  - clr_busy = (state == CLEAR), so it equals CLEAR_ON_RESET right after reset.
- Grants are combinational and are issued only when state == ARB, clr_start == 0 and reset == 0:
  - req0 only -> ack0 = 1.
  - req1 only -> ack1 = 1.
  - req0 and req1 together -> grant goes to the port that is not last_grant.
  - At most one ack is high in any cycle.
- Transfer edge (req_x && ack_x):
  - rf_rw <= 1, rf_da <= da_x, rf_d <= d_x, last_grant <= x.
  - The register_file writes on the next edge. Latency from request edge to register update is 2 edges.
  - The first contention after reset goes to port 0.
- ARB edge with no transfer: rf_rw <= 0; rf_da and rf_d hold their values.
- Requesters hold req, da and d stable until they see ack. Dropping req before ack is allowed and produces no write.
- Entering CLEAR: clr_start high in ARB -> state <= CLEAR, cnt <= 0. No grant is given in that cycle even if req0 or req1 is high.
- CLEAR, every edge:
  - rf_rw <= 1, rf_da <= cnt, rf_d <= CLEAR_VALUE, cnt <= cnt + 1.
  - When cnt == 2**ADDR_WIDTH - 1: state <= ARB, cnt <= 0.
  - Result: exactly 16 consecutive rf_rw pulses at addresses 0..15 in ascending order, and clr_busy is high for 16 cycles.
- clr_start while in CLEAR is ignored; the sweep does not restart.
- During CLEAR, ack0 = ack1 = 0 and pending requests wait.
- The first ARB cycle after a sweep may grant immediately. The write for address 15 and that granted write land on consecutive edges; there is no bubble.
- Reset in the middle of a sweep aborts it, sets rf_rw = 0, and restarts according to CLEAR_ON_RESET.
- cnt wraps from 15 to 0 only at sweep end. No arithmetic on data; values pass through unchanged.

Test Plan:
1. Reset high 2 cycles, CLEAR_ON_RESET = 1, no requests -> clr_busy high 16 cycles; rf_rw high for 16 cycles with rf_da = 0..15 and rf_d = 0; afterwards register_file reads A = B = 0 at all AA/BA.
2. After the sweep, req0 with da0 = 0, d0 = 16'h0005 -> ack0 = 1 in the same cycle; next cycle rf_rw = 1, rf_da = 0, rf_d = 5. Then req1 with da1 = 1, d1 = 16'h0006. Then AA = 0, BA = 1 -> A = 16'h0005, B = 16'h0006.
3. req0 and req1 both held high for 4 cycles, da0 = 2, d0 = 16'hAAAA, da1 = 3, d1 = 16'hBBBB, each requester dropping req after its ack -> acks in order 0 then 1; reg2 = AAAA, reg3 = BBBB. Continuous re-requests from both ports alternate 0,1,0,1.
4. clr_start in the same cycle as req1 -> ack1 = 0; the sweep runs. req1 is held and is acked in the first ARB cycle; its register holds d1 after the sweep. clr_start pulsed mid-sweep -> the sweep length stays 16.
5. reset asserted at sweep cycle 7 -> rf_rw = 0 the next cycle, then a full 16-cycle sweep starting at address 0.
6. CLEAR_ON_RESET = 0 -> clr_busy = 0 after reset, and req0 is acked in the first cycle after reset is released.
